// File: rtl/fb_pkg.sv
// Shared frame-buffer geometry, widths and enum types for the 128x96 VGA path.
package fb_pkg;
   localparam int unsigned FB_COLS  = 128;
   localparam int unsigned FB_ROWS  = 96;
   localparam int unsigned FB_DEPTH = FB_COLS * FB_ROWS;
   localparam int unsigned ADDR_W   = 14;
   localparam int unsigned DATA_W   = 3;

   typedef enum logic [1:0] {CLR_IDLE, CLR_FILL, CLR_DONE} clr_state_e;
   typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_HOST} rd_tag_e;

   typedef struct packed {
      rd_tag_e tag;
      logic    oor;
   } rd_tag_t;
endpackage

// File: rtl/fb_clear_engine.sv
// Frame-buffer fill engine: requests one write per cycle and advances only on grant.
module fb_clear_engine #(
   parameter int unsigned ADDR_W   = fb_pkg::ADDR_W,
   parameter int unsigned DATA_W   = fb_pkg::DATA_W,
   parameter int unsigned FB_DEPTH = fb_pkg::FB_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_i,
   input  logic [DATA_W-1:0] color_i,
   input  logic              grant_i,
   output logic              req_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] data_o,
   output logic              busy_o,
   output logic              done_o
);
   import fb_pkg::*;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

   clr_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] color_q, color_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= CLR_IDLE;
         addr_q  <= '0;
         color_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         color_q <= color_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      color_d = color_q;
      req_o   = 1'b0;
      busy_o  = 1'b0;
      done_o  = 1'b0;
      case (state_q)
         CLR_IDLE: begin
            if (start_i) begin
               color_d = color_i;
               addr_d  = '0;
               state_d = CLR_FILL;
            end
         end
         CLR_FILL: begin
            busy_o = 1'b1;
            req_o  = 1'b1;
            if (grant_i) begin
               if (addr_q == LAST_ADDR) state_d = CLR_DONE;
               else                     addr_d  = addr_q + ADDR_W'(1);
            end
         end
         CLR_DONE: begin
            busy_o  = 1'b1;
            done_o  = 1'b1;
            state_d = CLR_IDLE;
         end
         default: state_d = CLR_IDLE;
      endcase
   end

   assign addr_o = addr_q;
   assign data_o = color_q;
endmodule

// File: rtl/fb_arbiter.sv
// Single-port pixel RAM arbiter: scan-out > clear fill > host write > host read,
// with a tag pipeline steering read returns to the scan-out or host port.
module fb_arbiter #(
   parameter int unsigned ADDR_W   = fb_pkg::ADDR_W,
   parameter int unsigned DATA_W   = fb_pkg::DATA_W,
   parameter int unsigned FB_DEPTH = fb_pkg::FB_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_data,
   output logic              disp_valid,
   input  logic              wr_valid,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   input  logic              rd_valid,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_data_valid,
   input  logic              clear_start,
   input  logic [DATA_W-1:0] clear_color,
   output logic              clear_busy,
   output logic              clear_done,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   import fb_pkg::*;

   logic              clr_req, clr_grant;
   logic [ADDR_W-1:0] clr_addr;
   logic [DATA_W-1:0] clr_data;
   rd_tag_t           tag_q, tag_d;
   logic              disp_valid_q, rd_valid_q;
   logic [DATA_W-1:0] disp_data_q, rd_data_q;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return {1'b0, a} < (ADDR_W + 1)'(FB_DEPTH);
   endfunction

   fb_clear_engine #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .FB_DEPTH(FB_DEPTH)
   ) u_clear (
      .clk    (clk),
      .reset  (reset),
      .start_i(clear_start),
      .color_i(clear_color),
      .grant_i(clr_grant),
      .req_o  (clr_req),
      .addr_o (clr_addr),
      .data_o (clr_data),
      .busy_o (clear_busy),
      .done_o (clear_done)
   );

   // Ready and RAM strobes are forced low while reset is held so every output reads 0.
   always_comb begin
      wr_ready  = !reset && !disp_req && !clear_busy;
      rd_ready  = wr_ready && !wr_valid;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      clr_grant = 1'b0;
      tag_d     = '{tag: TAG_NONE, oor: 1'b0};
      if (!reset) begin
         if (disp_req) begin
            mem_en   = in_range(disp_addr);
            mem_addr = disp_addr;
            tag_d    = '{tag: TAG_DISP, oor: !in_range(disp_addr)};
         end else if (clr_req) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = clr_addr;
            mem_wdata = clr_data;
            clr_grant = 1'b1;
         end else if (wr_valid && wr_ready) begin
            mem_en    = in_range(wr_addr);
            mem_we    = in_range(wr_addr);
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
         end else if (rd_valid && rd_ready) begin
            mem_en   = in_range(rd_addr);
            mem_addr = rd_addr;
            tag_d    = '{tag: TAG_HOST, oor: !in_range(rd_addr)};
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tag_q        <= '{tag: TAG_NONE, oor: 1'b0};
         disp_valid_q <= 1'b0;
         disp_data_q  <= '0;
         rd_valid_q   <= 1'b0;
         rd_data_q    <= '0;
      end else begin
         tag_q        <= tag_d;
         disp_valid_q <= (tag_q.tag == TAG_DISP);
         disp_data_q  <= (tag_q.tag == TAG_DISP && !tag_q.oor) ? mem_rdata : '0;
         rd_valid_q   <= (tag_q.tag == TAG_HOST);
         rd_data_q    <= (tag_q.tag == TAG_HOST && !tag_q.oor) ? mem_rdata : '0;
      end
   end

   assign disp_valid    = disp_valid_q;
   assign disp_data     = disp_data_q;
   assign rd_data_valid = rd_valid_q;
   assign rd_data       = rd_data_q;
endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a behavioural single-port RAM attached.
module tb_fb_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        disp_req;
   logic [13:0] disp_addr;
   logic [2:0]  disp_data;
   logic        disp_valid;
   logic        wr_valid;
   logic [13:0] wr_addr;
   logic [2:0]  wr_data;
   logic        wr_ready;
   logic        rd_valid;
   logic [13:0] rd_addr;
   logic        rd_ready;
   logic [2:0]  rd_data;
   logic        rd_data_valid;
   logic        clear_start;
   logic [2:0]  clear_color;
   logic        clear_busy;
   logic        clear_done;
   logic        mem_en, mem_we;
   logic [13:0] mem_addr;
   logic [2:0]  mem_wdata;
   logic [2:0]  mem_rdata;

   int total = 0;
   int bad   = 0;

   logic       preload;
   logic [2:0] ram [0:12287];

   fb_arbiter #(.ADDR_W(14), .DATA_W(3), .FB_DEPTH(12288)) dut (
      .clk(clk), .reset(reset),
      .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
      .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
      .rd_data(rd_data), .rd_data_valid(rd_data_valid),
      .clear_start(clear_start), .clear_color(clear_color),
      .clear_busy(clear_busy), .clear_done(clear_done),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Unread cycles return all-ones so stale data cannot masquerade as a zero.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 12288; i++) ram[i] <= 3'(i);
         mem_rdata <= '1;
      end else begin
         if (mem_en && mem_we && mem_addr < 14'd12288) ram[mem_addr] <= mem_wdata;
         if (mem_en && !mem_we && mem_addr < 14'd12288) mem_rdata <= ram[mem_addr];
         else mem_rdata <= '1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_disp_valid"}, disp_valid, 0);
      chk({tag, "_disp_data"}, disp_data, 0);
      chk({tag, "_rd_data_valid"}, rd_data_valid, 0);
      chk({tag, "_rd_data"}, rd_data, 0);
      chk({tag, "_wr_ready"}, wr_ready, 0);
      chk({tag, "_rd_ready"}, rd_ready, 0);
      chk({tag, "_clear_busy"}, clear_busy, 0);
      chk({tag, "_clear_done"}, clear_done, 0);
      chk({tag, "_mem_en"}, mem_en, 0);
      chk({tag, "_mem_we"}, mem_we, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_mem_wdata"}, mem_wdata, 0);
   endtask

   initial begin
      int a, k, busy_cnt, rdy_bad, done_seen, ram_bad;
      reset = 1'b1; preload = 1'b1;
      disp_req = 0; disp_addr = '0; wr_valid = 0; wr_addr = '0; wr_data = '0;
      rd_valid = 0; rd_addr = '0; clear_start = 0; clear_color = '0;
      tick();
      preload = 1'b0;
      tick();
      chk_all_zero("reset");
      reset = 1'b0;
      tick();

      // Scan-out only, one request every 5th cycle
      for (int i = 0; i < 65; i++) begin
         a = (i == 64) ? 12287 : i * 193;
         disp_req = 1; disp_addr = 14'(a);
         tick();
         disp_req = 0;
         tick();
         chk("scan_valid", disp_valid, 1);
         chk("scan_data", disp_data, a % 8);
         tick();
         chk("scan_pulse", disp_valid, 0);
         tick();
         tick();
      end
      disp_req = 1; disp_addr = 14'd12290;
      tick();
      disp_req = 0;
      tick();
      chk("scan_oor_valid", disp_valid, 1);
      chk("scan_oor_data", disp_data, 0);
      tick();

      // Host write blocked by scan-out, then lands, then read back
      disp_req = 1; disp_addr = 14'd14;
      wr_valid = 1; wr_addr = 14'd300; wr_data = 3'd5;
      settle();
      chk("wr_blocked", wr_ready, 0);
      chk("scan_mem_we", mem_we, 0);
      chk("scan_mem_addr", mem_addr, 14);
      tick();
      disp_req = 0;
      settle();
      chk("wr_free", wr_ready, 1);
      chk("wr_mem_we", mem_we, 1);
      chk("wr_mem_addr", mem_addr, 300);
      chk("wr_mem_wdata", mem_wdata, 5);
      tick();
      wr_valid = 0; rd_valid = 1; rd_addr = 14'd300;
      settle();
      chk("scan14_valid", disp_valid, 1);
      chk("scan14_data", disp_data, 6);
      chk("rd_ready_300", rd_ready, 1);
      tick();
      rd_valid = 0;
      tick();
      chk("rd300_valid", rd_data_valid, 1);
      chk("rd300_data", rd_data, 5);
      tick();
      chk("rd300_pulse", rd_data_valid, 0);

      // Simultaneous write and read: write first
      wr_valid = 1; wr_addr = 14'd400; wr_data = 3'd6;
      rd_valid = 1; rd_addr = 14'd400;
      settle();
      chk("wr_rd_rd_ready", rd_ready, 0);
      chk("wr_rd_wr_ready", wr_ready, 1);
      chk("wr_rd_mem_we", mem_we, 1);
      tick();
      wr_valid = 0;
      settle();
      chk("rd400_ready", rd_ready, 1);
      chk("rd400_mem_we", mem_we, 0);
      chk("rd400_mem_addr", mem_addr, 400);
      tick();
      rd_valid = 0;
      tick();
      chk("rd400_valid", rd_data_valid, 1);
      chk("rd400_data", rd_data, 6);

      // Out-of-range host write and read
      wr_valid = 1; wr_addr = 14'd12288; wr_data = 3'd7;
      settle();
      chk("oor_wr_ready", wr_ready, 1);
      chk("oor_wr_mem_en", mem_en, 0);
      tick();
      wr_valid = 0; rd_valid = 1; rd_addr = 14'd12290;
      settle();
      chk("oor_rd_ready", rd_ready, 1);
      chk("oor_rd_mem_en", mem_en, 0);
      tick();
      rd_valid = 0;
      tick();
      chk("oor_rd_valid", rd_data_valid, 1);
      chk("oor_rd_data", rd_data, 0);
      tick();

      // Full clear with host traffic held off and a second start ignored
      clear_start = 1; clear_color = 3'd3;
      tick();
      clear_start = 0;
      wr_valid = 1; wr_addr = 14'd0; wr_data = 3'd7;
      rd_valid = 1; rd_addr = 14'd5;
      settle();
      chk("clr_busy_start", clear_busy, 1);
      k = 1; busy_cnt = 0; rdy_bad = 0; done_seen = 0;
      while (k < 13000) begin
         if (clear_busy) busy_cnt++;
         if (wr_ready || rd_ready) rdy_bad++;
         if (clear_done) begin
            done_seen = 1;
            wr_valid = 0; rd_valid = 0;
            break;
         end
         if (k == 100) begin clear_start = 1; clear_color = 3'd5; end
         else clear_start = 0;
         tick();
         settle();
         k++;
      end
      clear_start = 0;
      chk("clr_done_seen", done_seen, 1);
      chk("clr_done_cycle", k, 12289);
      chk("clr_busy_cycles", busy_cnt, 12289);
      chk("clr_host_ready", rdy_bad, 0);
      tick();
      settle();
      chk("clr_busy_after", clear_busy, 0);
      chk("clr_done_pulse", clear_done, 0);
      ram_bad = 0;
      for (int i = 0; i < 12288; i++) if (ram[i] !== 3'd3) ram_bad++;
      chk("clr_ram_contents", ram_bad, 0);
      rd_valid = 1; rd_addr = 14'd0;
      tick();
      rd_addr = 14'd12287;
      tick();
      rd_valid = 0;
      settle();
      chk("clr_rd0_valid", rd_data_valid, 1);
      chk("clr_rd0_data", rd_data, 3);
      tick();
      chk("clr_rdlast_valid", rd_data_valid, 1);
      chk("clr_rdlast_data", rd_data, 3);
      tick();
      chk("clr_rd_pulse", rd_data_valid, 0);

      // Reset mid-fill, then restart coincident with scan-out
      clear_start = 1; clear_color = 3'd6;
      tick();
      clear_start = 0;
      settle();
      k = 0;
      while (!(mem_we && mem_addr == 14'd5000) && k < 6000) begin
         tick();
         settle();
         k++;
      end
      chk("mid_fill_addr", mem_addr, 5000);
      reset = 1'b1;
      settle();
      chk_all_zero("mid_reset");
      tick();
      chk("mid_reset_done", clear_done, 0);
      reset = 1'b0;
      tick();
      chk("post_reset_busy", clear_busy, 0);
      chk("post_reset_done", clear_done, 0);
      tick();
      chk("post_reset_done2", clear_done, 0);
      clear_start = 1; clear_color = 3'd1;
      disp_req = 1; disp_addr = 14'd9;
      settle();
      chk("restart_scan_we", mem_we, 0);
      chk("restart_scan_addr", mem_addr, 9);
      tick();
      clear_start = 0; disp_req = 0;
      settle();
      chk("restart_busy", clear_busy, 1);
      chk("restart_we", mem_we, 1);
      chk("restart_addr0", mem_addr, 0);
      chk("restart_wdata", mem_wdata, 1);
      tick();
      disp_req = 1; disp_addr = 14'd10;
      settle();
      chk("stall_we", mem_we, 0);
      chk("stall_addr", mem_addr, 10);
      tick();
      disp_req = 0;
      settle();
      chk("resume_we", mem_we, 1);
      chk("resume_addr1", mem_addr, 1);
      reset = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Single-port frame-buffer arbiter for the 128x96 VGA display path. Shares one synchronous single-port pixel RAM between the scan-out fetch (driven by the hsync/vsync pixel counters), a host read/write port, and a built-in clear engine. Scan-out has absolute priority and is never stalled. The host and clear engine use the remaining cycles.

## Interface
Parameters:
- ADDR_W, 14, pixel address width (addr = row*128 + col)
- DATA_W, 3, pixel width (R,G,B one bit each)
- FB_DEPTH, 12288, valid addresses 0..FB_DEPTH-1

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high
- disp_req  in  1  scan-out fetch request, single-cycle pulse
- disp_addr  in  ADDR_W  scan-out pixel address
- disp_data  out  DATA_W  fetched pixel
- disp_valid  out  1  disp_data valid, one-cycle pulse
- wr_valid  in  1  host write request
- wr_addr  in  ADDR_W  host write address
- wr_data  in  DATA_W  host write data
- wr_ready  out  1  host write accepted when wr_valid && wr_ready
- rd_valid  in  1  host read request
- rd_addr  in  ADDR_W  host read address
- rd_ready  out  1  host read accepted when rd_valid && rd_ready
- rd_data  out  DATA_W  host read data
- rd_data_valid  out  1  rd_data valid, one-cycle pulse
- clear_start  in  1  start fill, pulse
- clear_color  in  DATA_W  fill value, sampled on accepted clear_start
- clear_busy  out  1  fill in progress
- clear_done  out  1  one-cycle pulse after last fill write
- mem_en, mem_we  out  1 each  RAM enable / write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_en && !mem_we

## Operation
- Each cycle the RAM port performs at most one access. Fixed priority: disp_req > clear write > host write > host read.
- wr_ready = !disp_req && !clear_busy. This is combinational, and the write is issued in the same cycle it is accepted.
- rd_ready = !disp_req && !clear_busy && !wr_valid. Writes win over reads in the same cycle.
- Out-of-range address (>= FB_DEPTH):
  - Host write: accepted, mem_en held 0, data dropped.
  - Host read: accepted, no RAM access, rd_data = 0 with normal latency.
  - Scan-out: disp_data = 0.
- Clear engine states:
  - IDLE: an accepted clear_start latches clear_color and sets the address counter to 0 → FILL. clear_start is ignored while not IDLE.
  - FILL: writes clear_color at the counter in every cycle without disp_req, incrementing after each write. After writing FB_DEPTH-1 → DONE.
  - DONE: clear_done = 1 for one cycle, clear_busy falls → IDLE.
- clear_busy = 1 in FILL and DONE.
- Read-return tracking: a 2-deep tag pipeline (NONE/DISP/HOST plus an out-of-range flag) routes mem_rdata to the correct output.
- Reset values: all outputs 0. Clear engine returns to IDLE and the tag pipeline is flushed. Reset mid-fill abandons the fill with no clear_done.

## Timing
- Scan-out: disp_req at cycle N → mem access in N → disp_valid/disp_data registered in N+2. Fixed latency, never stalled.
- Host read: accept at N → rd_data_valid in N+2.
- Host write: accept at N → RAM written at N's clock edge. A read accepted at N+1 to the same address returns the new data.
- Clear duration is FB_DEPTH cycles plus the cycles lost to disp_req, plus 1 for DONE. With no scan-out traffic: clear_start at N → clear_done at N+12289.
- disp_req and clear_start in the same cycle: the fill is accepted and starts writing next free cycle. Scan-out is served.
- Back-to-back host reads at 1 per cycle are supported with no bubbles.

## Structure
- Shared package fb_pkg holds:
  - FB_COLS=128, FB_ROWS=96, FB_DEPTH, ADDR_W, DATA_W
  - the clear-state enum {CLR_IDLE, CLR_FILL, CLR_DONE}
  - the read-tag enum {TAG_NONE, TAG_DISP, TAG_HOST}
- Sub-module fb_clear_engine: state machine plus address counter. It exposes a request/address/data interface and advances on a grant from fb_arbiter.
- The arbiter mux and the tag pipeline stay in fb_arbiter.

## Test plan
- Scan-out only, disp_req every 5th cycle, addr 0..12287 with RAM preloaded addr[2:0] → disp_data = addr[2:0] exactly 2 cycles after each request, no gaps.
- Host write 0x5 to addr 300 coincident with disp_req → wr_ready=0 that cycle. Write lands the next cycle. Host read of 300 → rd_data=0x5 at +2.
- wr_valid and rd_valid together, no disp_req → write issued first, rd_ready=0. Read accepted the following cycle.
- Host write to addr 12288 → accepted, mem_en=0. Read of 12290 → rd_data=0, rd_data_valid at +2.
- clear_start with color 0x3 and no scan-out → clear_busy for 12289 cycles, clear_done pulse, all 12288 locations read 0x3. Host ready=0 throughout. A second clear_start mid-fill is ignored.
- Assert reset at fill address 5000 → all outputs 0, no clear_done. A new clear_start after reset restarts at address 0.
